// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the ALU: 31-entry register file, RV32I decode, one-entry output buffer.
// Optional: define ALU_OPSTAGE_REFRESH_EN to refresh held register operands from writeback while stalled.
`ifndef XBUS
`define XBUS 31:0
`endif
`ifndef ALU_OP_MSB
`define ALU_OP_MSB 3
`endif

module alu_operand_stage #(
    parameter logic [`XBUS] RF_RESET_VAL = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [`XBUS]        in_pc,
    input  logic                wb_en,
    input  logic [4:0]          wb_rd,
    input  logic [`XBUS]        wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [`XBUS]        out_a,
    output logic [`XBUS]        out_b,
    output logic [`ALU_OP_MSB:0] out_op,
    output logic                out_is_cond,
    output logic [4:0]          out_rd,
    output logic                out_rd_we,
    output logic [`XBUS]        out_imm,
    output logic [`XBUS]        out_pc,
    output logic                out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [`XBUS] rf_r [1:31];

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic        f7b_s;
    logic [4:0]  rs1_idx_s;
    logic [4:0]  rs2_idx_s;
    logic [4:0]  rd_idx_s;
    logic [`XBUS] imm_i_s;
    logic [`XBUS] imm_b_s;
    logic [`XBUS] imm_u_s;
    logic [`XBUS] rs1_val_s;
    logic [`XBUS] rs2_val_s;
    logic        accept_s;

    logic [`XBUS]         dec_a_s;
    logic [`XBUS]         dec_b_s;
    logic [`ALU_OP_MSB:0] dec_op_s;
    logic                 dec_cond_s;
    logic [4:0]           dec_rd_s;
    logic                 dec_we_s;
    logic                 dec_rd_we_s;
    logic [`XBUS]         dec_imm_s;
    logic                 dec_illegal_s;
    logic                 dec_a_reg_s;
    logic                 dec_b_reg_s;

`ifdef ALU_OPSTAGE_REFRESH_EN
    logic [4:0] rs1_idx_r;
    logic [4:0] rs2_idx_r;
    logic       a_reg_r;
    logic       b_reg_r;
`endif

    assign opcode_s  = in_instr[6:0];
    assign f3_s      = in_instr[14:12];
    assign f7b_s     = in_instr[30];
    assign rs1_idx_s = in_instr[19:15];
    assign rs2_idx_s = in_instr[24:20];
    assign rd_idx_s  = in_instr[11:7];
    assign imm_i_s   = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_b_s   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s   = {in_instr[31:12], 12'h000};

    assign in_ready = !out_valid || out_ready;
    assign accept_s = in_valid && in_ready;

    // Register-file read with same-cycle writeback bypass; x0 always reads zero.
    always_comb begin
        rs1_val_s = 32'h0000_0000;
        rs2_val_s = 32'h0000_0000;
        if (rs1_idx_s == 5'd0) begin
            rs1_val_s = 32'h0000_0000;
        end else if (wb_en && (wb_rd == rs1_idx_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_r[rs1_idx_s];
        end
        if (rs2_idx_s == 5'd0) begin
            rs2_val_s = 32'h0000_0000;
        end else if (wb_en && (wb_rd == rs2_idx_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_r[rs2_idx_s];
        end
    end

    // Instruction decode into ALU operands and control.
    always_comb begin
        dec_a_s       = 32'h0000_0000;
        dec_b_s       = 32'h0000_0000;
        dec_op_s      = 4'b0000;
        dec_cond_s    = 1'b0;
        dec_rd_s      = 5'd0;
        dec_we_s      = 1'b0;
        dec_imm_s     = 32'h0000_0000;
        dec_illegal_s = 1'b0;
        dec_a_reg_s   = 1'b0;
        dec_b_reg_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_a_s     = rs1_val_s;
                dec_b_s     = rs2_val_s;
                dec_op_s    = {f7b_s, f3_s};
                dec_rd_s    = rd_idx_s;
                dec_we_s    = 1'b1;
                dec_a_reg_s = 1'b1;
                dec_b_reg_s = 1'b1;
            end
            OPC_OPIMM: begin
                dec_a_s     = rs1_val_s;
                dec_b_s     = imm_i_s;
                dec_imm_s   = imm_i_s;
                // Only the right shifts use instr[30] to pick arithmetic vs logical.
                if (f3_s == 3'b101) begin
                    dec_op_s = {f7b_s, f3_s};
                end else begin
                    dec_op_s = {1'b0, f3_s};
                end
                dec_rd_s    = rd_idx_s;
                dec_we_s    = 1'b1;
                dec_a_reg_s = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a_s     = rs1_val_s;
                dec_b_s     = rs2_val_s;
                dec_op_s    = {1'b0, f3_s};
                dec_cond_s  = 1'b1;
                dec_imm_s   = imm_b_s;
                dec_a_reg_s = 1'b1;
                dec_b_reg_s = 1'b1;
            end
            OPC_LUI: begin
                dec_b_s   = imm_u_s;
                dec_imm_s = imm_u_s;
                dec_rd_s  = rd_idx_s;
                dec_we_s  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a_s   = in_pc;
                dec_b_s   = imm_u_s;
                dec_imm_s = imm_u_s;
                dec_rd_s  = rd_idx_s;
                dec_we_s  = 1'b1;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
        dec_rd_we_s = dec_we_s && (dec_rd_s != 5'd0);
    end

    // Register file x1..x31; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                rf_r[i] <= RF_RESET_VAL;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    // One-entry output buffer toward the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_a       <= 32'h0000_0000;
            out_b       <= 32'h0000_0000;
            out_op      <= 4'b0000;
            out_is_cond <= 1'b0;
            out_rd      <= 5'd0;
            out_rd_we   <= 1'b0;
            out_imm     <= 32'h0000_0000;
            out_pc      <= 32'h0000_0000;
            out_illegal <= 1'b0;
`ifdef ALU_OPSTAGE_REFRESH_EN
            rs1_idx_r   <= 5'd0;
            rs2_idx_r   <= 5'd0;
            a_reg_r     <= 1'b0;
            b_reg_r     <= 1'b0;
`endif
        end else if (accept_s) begin
            out_valid   <= 1'b1;
            out_a       <= dec_a_s;
            out_b       <= dec_b_s;
            out_op      <= dec_op_s;
            out_is_cond <= dec_cond_s;
            out_rd      <= dec_rd_s;
            out_rd_we   <= dec_rd_we_s;
            out_imm     <= dec_imm_s;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal_s;
`ifdef ALU_OPSTAGE_REFRESH_EN
            rs1_idx_r   <= rs1_idx_s;
            rs2_idx_r   <= rs2_idx_s;
            a_reg_r     <= dec_a_reg_s;
            b_reg_r     <= dec_b_reg_s;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
`ifdef ALU_OPSTAGE_REFRESH_EN
        else if (out_valid && wb_en && (wb_rd != 5'd0)) begin
            if (a_reg_r && (wb_rd == rs1_idx_r)) begin
                out_a <= wb_data;
            end
            if (b_reg_r && (wb_rd == rs2_idx_r)) begin
                out_b <= wb_data;
            end
        end
`endif
    end

`ifndef ALU_OPSTAGE_REFRESH_EN
    logic unused_src_flags_s;
    assign unused_src_flags_s = dec_a_reg_s ^ dec_b_reg_s;
`endif

endmodule
